mul_add_row: RTL and testbench

Word-serial Montgomery row engine: streams one multi-word operand through a single `DATA_WIDTH`×`DATA_WIDTH` multiply-add, computing {c, s} = x_i·y + z_i + c_prev per word with the carry chained internally, and finishes by emitting the final carry as an extra word. It is the parametrised, handshaked, registered successor of the combinational per-word multiply-add cell. MonPro uses it to compute one full row (A·b_j + T) per start.

---
 rtl/mul_add_row_if.sv | 29 ++
 rtl/mul_add_row.sv | 148 ++++++++++++++
 tb/tb_mul_add_row.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_add_row_if.sv
// Handshake bundle for the mul_add_row word-serial multiply-add engine.
// The master drives row control and operand words; the slave is the engine.
interface mul_add_row_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] y;
  logic [DATA_WIDTH-1:0] carry_in;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] z;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  done;

  modport master (
    output start, y, carry_in, in_valid, x, z, out_ready,
    input  busy, in_ready, out_valid, out_data, out_last, done
  );

  modport slave (
    input  start, y, carry_in, in_valid, x, z, out_ready,
    output busy, in_ready, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/mul_add_row.sv
// Word-serial Montgomery row engine: {c, s} = x_i*y + z_i + c per word, with the
// carry chained internally and emitted as an extra (last) word after N words.
module mul_add_row #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic         clk,
  input  logic         reset,
  mul_add_row_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CARRY = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [W-1:0]           y_r;
  logic [W-1:0]           c_reg_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [W-1:0]           out_data_r;
  logic                   out_valid_r;
  logic                   out_last_r;
  logic                   busy_r;
  logic                   done_r;

  logic                   slot_free_s;
  logic                   in_ready_s;
  logic                   in_xfer_s;
  logic                   out_xfer_s;
  logic                   last_word_s;
  logic                   start_acc_s;
  logic                   load_carry_s;
  logic                   finish_s;
  logic [2*W-1:0]         sum_s;

  // (2^W-1)^2 + 2(2^W-1) = 2^2W-1, so the 2W-bit sum can never overflow.
  assign sum_s = ({{W{1'b0}}, bus.x} * {{W{1'b0}}, y_r})
               + {{W{1'b0}}, bus.z}
               + {{W{1'b0}}, c_reg_r};

  assign slot_free_s = !out_valid_r || bus.out_ready;
  assign in_ready_s  = (state_r == RUN) && slot_free_s;
  assign in_xfer_s   = bus.in_valid && in_ready_s;
  assign out_xfer_s  = out_valid_r && bus.out_ready;
  assign last_word_s = (cnt_r == CNT_WIDTH'(NUM_WORDS - 1));

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Row sequencing: IDLE -> RUN (N words) -> CARRY (emit carry) -> IDLE.
  always_comb begin
    state_next_s = state_r;
    start_acc_s  = 1'b0;
    load_carry_s = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // done_r still high means the row just ended; a start here is dropped.
        if (bus.start && !done_r) begin
          start_acc_s  = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (in_xfer_s && last_word_s) begin
          state_next_s = CARRY;
        end else begin
          state_next_s = RUN;
        end
      end
      CARRY: begin
        if (out_last_r && out_xfer_s) begin
          finish_s     = 1'b1;
          state_next_s = IDLE;
        end else if (!out_last_r && slot_free_s) begin
          load_carry_s = 1'b1;
          state_next_s = CARRY;
        end else begin
          state_next_s = CARRY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, carry chain, word counter and the single output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r         <= {W{1'b0}};
      c_reg_r     <= {W{1'b0}};
      cnt_r       <= {CNT_WIDTH{1'b0}};
      out_data_r  <= {W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= finish_s;

      if (start_acc_s) begin
        y_r     <= bus.y;
        c_reg_r <= bus.carry_in;
        cnt_r   <= {CNT_WIDTH{1'b0}};
        busy_r  <= 1'b1;
      end else if (finish_s) begin
        busy_r  <= 1'b0;
      end else if (in_xfer_s) begin
        c_reg_r <= sum_s[2*W-1:W];
        cnt_r   <= cnt_r + CNT_WIDTH'(1);
      end

      if (in_xfer_s) begin
        out_data_r  <= sum_s[W-1:0];
        out_valid_r <= 1'b1;
        out_last_r  <= 1'b0;
      end else if (load_carry_s) begin
        out_data_r  <= c_reg_r;
        out_valid_r <= 1'b1;
        out_last_r  <= 1'b1;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_add_row.sv
// Directed bench for mul_add_row at W=8, N=4: each task drives one scenario
// and compares observed words/flags against hand-computed values.
module tb_mul_add_row;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  mul_add_row_if #(.DATA_WIDTH(8)) bus ();

  mul_add_row #(
    .DATA_WIDTH(8),
    .NUM_WORDS (4),
    .CNT_WIDTH (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one row; mode 0 = full throughput, 1 = backpressure + random valid,
  // 2 = extra start pulse while running. Returns what was observed.
  task automatic drive_row(input logic [7:0] yv, input logic [7:0] cv,
                           input logic [3:0][7:0] xv, input logic [3:0][7:0] zv,
                           input int mode,
                           output logic [4:0][7:0] got, output logic [4:0] lasts,
                           output int nout, output int stall_err, output int rdy_err,
                           output int done_gap, output bit timeout);
    int idx;
    int cyc;
    int carry_cyc;
    bit held;
    bit fin;
    logic [7:0] held_data;
    idx = 0; cyc = 0; carry_cyc = -100; held = 1'b0; fin = 1'b0; held_data = 8'h00;
    got = '0; lasts = '0; nout = 0; stall_err = 0; rdy_err = 0; done_gap = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.y = yv; bus.carry_in = cv; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!fin && cyc < 200) begin
      bus.in_valid  = (idx < 4) && ((mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1);
      bus.x         = (idx < 4) ? xv[idx] : 8'h00;
      bus.z         = (idx < 4) ? zv[idx] : 8'h00;
      bus.out_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      bus.start     = (mode == 2) && (cyc == 1);
      #1;
      if (held && bus.out_valid && (bus.out_data !== held_data)) stall_err++;
      if (bus.out_valid && !bus.out_ready && bus.in_ready) rdy_err++;
      if (bus.done) begin
        done_gap = cyc - carry_cyc;
        fin = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (nout < 5) begin
          got[nout]   = bus.out_data;
          lasts[nout] = bus.out_last;
        end
        if (bus.out_last) carry_cyc = cyc;
        nout++;
      end
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
      if (!fin) @(negedge clk);
    end
    timeout = !fin;
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.y = 8'h00; bus.carry_in = 8'h00; bus.in_valid = 1'b0;
    bus.x = 8'h00; bus.z = 8'h00; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done} !== 5'b00000)
      $display("FAIL reset_flags got=%b want=00000",
               {bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done});
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 8'h00) $display("FAIL reset_data got=%h want=00", bus.out_data);
    else pass_cnt++;
    reset = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // Shared body for the plain-row scenarios; comparisons stay inline here.
  task automatic test_row(input string name, input logic [7:0] yv, input logic [7:0] cv,
                          input logic [3:0][7:0] xv, input logic [3:0][7:0] zv,
                          input logic [4:0][7:0] exp, input int mode);
    logic [4:0][7:0] got;
    logic [4:0]      lasts;
    int nout, stall_err, rdy_err, done_gap;
    bit timeout;
    drive_row(yv, cv, xv, zv, mode, got, lasts, nout, stall_err, rdy_err, done_gap, timeout);
    total_cnt++;
    if (timeout) $display("FAIL %s_timeout got=no_done want=done", name);
    else pass_cnt++;
    total_cnt++;
    if (nout !== 5) $display("FAIL %s_count got=%0d want=5", name, nout);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (got[i] !== exp[i]) $display("FAIL %s_word%0d got=%h want=%h", name, i, got[i], exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (lasts !== 5'b10000) $display("FAIL %s_last got=%b want=10000", name, lasts);
    else pass_cnt++;
    total_cnt++;
    if (done_gap !== 1) $display("FAIL %s_done_gap got=%0d want=1", name, done_gap);
    else pass_cnt++;
    total_cnt++;
    if ((stall_err !== 0) || (rdy_err !== 0))
      $display("FAIL %s_stall got=%0d/%0d want=0/0", name, stall_err, rdy_err);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ((bus.busy !== 1'b0) || (bus.out_valid !== 1'b0))
      $display("FAIL %s_idle_after got=%b%b want=00", name, bus.busy, bus.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    test_row("basic", 8'h02, 8'h00, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h0,
             {8'h00, 8'h08, 8'h06, 8'h04, 8'h02}, 0);
  endtask

  task automatic test_carry_chain();
    test_row("chain", 8'h10, 8'h00, {8'h20, 8'h20, 8'h20, 8'h20}, 32'h0,
             {8'h02, 8'h02, 8'h02, 8'h02, 8'h00}, 0);
  endtask

  task automatic test_max_values();
    test_row("max", 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             40'hFF_FFFF_FFFF, 0);
  endtask

  task automatic test_backpressure();
    test_row("bp", 8'h02, 8'h00, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h0,
             {8'h00, 8'h08, 8'h06, 8'h04, 8'h02}, 1);
  endtask

  task automatic test_protocol_abuse();
    bit seen;
    // in_valid while idle must not consume or produce anything.
    seen = 1'b0;
    bus.x = 8'h05; bus.z = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      #1;
      if (bus.out_valid || bus.in_ready) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    total_cnt++;
    if (seen) $display("FAIL idle_in_valid got=activity want=none");
    else pass_cnt++;
    // start during RUN is ignored; the row result is unchanged.
    test_row("abuse", 8'h02, 8'h00, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h0,
             {8'h00, 8'h08, 8'h06, 8'h04, 8'h02}, 2);
    // start in the done cycle is ignored.
    drive_done_start();
  endtask

  task automatic drive_done_start();
    logic [4:0][7:0] got;
    logic [4:0]      lasts;
    int nout, stall_err, rdy_err, done_gap;
    bit timeout;
    drive_row(8'h03, 8'h00, {8'd1, 8'd1, 8'd1, 8'd1}, 32'h0, 0,
              got, lasts, nout, stall_err, rdy_err, done_gap, timeout);
    total_cnt++;
    if (got[0] !== 8'h03) $display("FAIL done_row_word0 got=%h want=03", got[0]);
    else pass_cnt++;
    bus.start = 1'b1; bus.y = 8'h07;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    total_cnt++;
    if ((bus.busy !== 1'b0) || (bus.in_ready !== 1'b0))
      $display("FAIL start_in_done got=%b%b want=00", bus.busy, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_row();
    @(negedge clk);
    bus.start = 1'b1; bus.y = 8'h02; bus.carry_in = 8'h00; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.x = 8'd1; bus.z = 8'd0;
    @(negedge clk);
    bus.x = 8'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done} !== 5'b00000)
      $display("FAIL midreset_flags got=%b want=00000",
               {bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done});
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 8'h00) $display("FAIL midreset_data got=%h want=00", bus.out_data);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    test_row("after_reset", 8'h02, 8'h00, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h0,
             {8'h00, 8'h08, 8'h06, 8'h04, 8'h02}, 0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_max_values();
    test_backpressure();
    test_protocol_abuse();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
